// File: rtl/fetch_queue_unit.sv
// Fetch front end: sequential imem requests, PC-tagged in-order queue to
// decode, redirect flush with stale-response draining.
module fetch_queue_unit #(
    parameter int               WIDTH    = 32,
    parameter int               QDEPTH   = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   QD_OCC  = (CW+1)'(QDEPTH);
    localparam logic [CW-1:0] QD_FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] fetch_pc, fetch_nx;
    logic [WIDTH-1:0] q_instr [QDEPTH];
    logic [WIDTH-1:0] q_pc    [QDEPTH];
    logic [WIDTH-1:0] a_fifo  [QDEPTH];
    logic [PW-1:0]    head, tail, a_wr, a_rd, head_nx;
    logic [CW-1:0]    count, inflight, stale;
    logic [CW-1:0]    count_nx, inflight_nx, stale_nx;
    logic [CW:0]      occ_nx;
    logic             req_fire, pop, push, fresh;
    logic [WIDTH-1:0] resp_pc, nx_instr, nx_pc;

    assign imem_req_addr = fetch_pc;
    assign resp_pc       = a_fifo[a_rd];
    assign occ_nx        = {1'b0, count_nx} + {1'b0, inflight_nx};

    always_comb begin
        req_fire    = imem_req_valid & imem_req_ready;
        pop         = id_valid & id_ready;
        // a response landing in a redirect cycle is from the old stream
        push        = imem_resp_valid & (stale == '0) & ~redirect_valid;
        inflight_nx = inflight + CW'(req_fire) - CW'(imem_resp_valid);
        count_nx    = count + CW'(push) - CW'(pop);
        head_nx     = head + PW'(pop);
        stale_nx    = stale;
        fetch_nx    = fetch_pc + (req_fire ? WIDTH'(4) : '0);
        state_nx    = state;
        if (imem_resp_valid && stale != '0)
            stale_nx = stale - 1'b1;
        if (redirect_valid) begin
            count_nx = '0;
            head_nx  = '0;
            stale_nx = inflight_nx;
            fetch_nx = redirect_pc & ~WIDTH'(3);
        end
        if (state == BOOT)
            state_nx = RUN;
        else if (redirect_valid)
            state_nx = (inflight_nx != '0) ? DRAIN : RUN;
        else if (state == DRAIN && stale_nx == '0)
            state_nx = RUN;
        // head after this edge is the incoming response when nothing older remains
        fresh    = (count == CW'(pop));
        nx_instr = fresh ? imem_resp_data : q_instr[head_nx];
        nx_pc    = fresh ? resp_pc : q_pc[head_nx];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_resp_data;
            q_pc[tail]    <= resp_pc;
        end
        if (req_fire)
            a_fifo[a_wr] <= fetch_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= BOOT;
            fetch_pc       <= RESET_PC;
            head           <= '0;
            tail           <= '0;
            a_wr           <= '0;
            a_rd           <= '0;
            count          <= '0;
            inflight       <= '0;
            stale          <= '0;
            imem_req_valid <= 1'b0;
            id_valid       <= 1'b0;
            id_instr       <= '0;
            id_pc          <= '0;
            id_pc_plus4    <= '0;
        end else begin
            state          <= state_nx;
            fetch_pc       <= fetch_nx;
            head           <= head_nx;
            tail           <= redirect_valid ? '0 : tail + PW'(push);
            a_wr           <= a_wr + PW'(req_fire);
            a_rd           <= a_rd + PW'(imem_resp_valid);
            count          <= count_nx;
            inflight       <= inflight_nx;
            stale          <= stale_nx;
            imem_req_valid <= (state_nx == RUN) && (occ_nx < QD_OCC);
            id_valid       <= (count_nx != '0);
            if (count_nx != '0) begin
                id_instr    <= nx_instr;
                id_pc       <= nx_pc;
                id_pc_plus4 <= nx_pc + WIDTH'(4);
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(imem_resp_valid && count == QD_FULL));
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-level model of
// the fetch stream, with directed redirect, wrap and reset scenarios.
module tb_fetch_queue_unit;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    fetch_queue_unit #(.WIDTH(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fires = 0;

    int lat_min = 1, lat_max = 1;
    int p_rdy = 100, p_idr = 100, p_redir = 0;
    bit f_redir = 1'b0;
    logic [31:0] f_rpc = '0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];

    bit          m_boot;
    logic [31:0] m_fpc;
    logic [31:0] m_qi[$];
    logic [31:0] m_qp[$];
    logic [31:0] m_pend[$];
    int          m_stale;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    function automatic bit m_rv();
        return !m_boot && m_stale == 0 &&
               (m_qi.size() + m_pend.size() < QD);
    endfunction

    task automatic compare();
        bit rv;
        rv = m_rv();
        chk("req_valid", 32'(imem_req_valid), 32'(rv));
        if (rv)
            chk("req_addr", imem_req_addr, m_fpc);
        chk("id_valid", 32'(id_valid), 32'(m_qi.size() > 0));
        if (m_qi.size() > 0) begin
            chk("id_instr", id_instr, m_qi[0]);
            chk("id_pc", id_pc, m_qp[0]);
            chk("id_pc_plus4", id_pc_plus4, m_qp[0] + 32'd4);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance memory and model.
    task automatic step();
        bit          rv, rdy, idr, rd, rsp;
        logic [31:0] rdata, rpc, a;
        mreq_t       mr;
        compare();
        rv    = m_rv();
        rdy   = int'($urandom_range(99)) < p_rdy;
        idr   = int'($urandom_range(99)) < p_idr;
        rd    = f_redir || (int'($urandom_range(999)) < p_redir);
        rpc   = f_redir ? f_rpc : $urandom;
        rsp   = mem_q.size() > 0 && mem_q[0].due <= cyc;
        rdata = $urandom;
        if (rsp) begin
            rdata = mem_data(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rdata;
        id_ready        = idr;
        redirect_valid  = rd;
        redirect_pc     = rpc;
        if (imem_req_valid && rdy) begin
            mr.addr = imem_req_addr;
            mr.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mem_q.push_back(mr);
            fires++;
        end
        if (m_qi.size() > 0 && idr) begin
            void'(m_qi.pop_front());
            void'(m_qp.pop_front());
        end
        if (rsp && m_pend.size() > 0) begin
            a = m_pend.pop_front();
            if (m_stale > 0)
                m_stale--;
            else if (!rd) begin
                m_qi.push_back(rdata);
                m_qp.push_back(a);
            end
        end
        if (rv && rdy) begin
            m_pend.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
        end
        if (rd) begin
            m_qi.delete();
            m_qp.delete();
            m_fpc   = rpc & ~32'd3;
            m_stale = m_pend.size();
        end
        m_boot = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        mem_q.delete();
        m_qi.delete();
        m_qp.delete();
        m_pend.delete();
        m_boot  = 1'b1;
        m_fpc   = 32'h0;
        m_stale = 0;
        fires   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_id_instr"}, id_instr, 32'd0);
        chk({tag, "_id_pc"}, id_pc, 32'd0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        #1 rst = 1'b0;
        #1 chk_reset_outs("por");

        // Reset release, 1-cycle memory, decode always ready
        do_reset();
        step();
        chk("A_req0_valid", 32'(imem_req_valid), 32'd1);
        chk("A_req0_addr", imem_req_addr, 32'h0);
        step();
        chk("A_c2_id_valid", 32'(id_valid), 32'd0);
        chk("A_c2_addr", imem_req_addr, 32'h4);
        step();
        chk("A_c3_id_valid", 32'(id_valid), 32'd1);
        chk("A_c3_id_pc", id_pc, 32'h0);
        chk("A_c3_plus4", id_pc_plus4, 32'h4);
        step();
        chk("A_c4_id_pc", id_pc, 32'h4);
        step();
        chk("A_c5_id_pc", id_pc, 32'h8);
        chk("A_c5_plus4", id_pc_plus4, 32'hC);
        repeat (10) step();

        // Decode stalled: occupancy cap, then resume in order
        do_reset();
        p_idr = 0;
        repeat (10) step();
        chk("B_fires", 32'(fires), 32'd4);
        chk("B_req_valid", 32'(imem_req_valid), 32'd0);
        chk("B_head_pc", id_pc, 32'h0);
        p_idr = 100;
        step();
        chk("B_pop1_pc", id_pc, 32'h4);
        step();
        chk("B_pop2_pc", id_pc, 32'h8);
        repeat (12) step();

        // 3-cycle memory, redirect with 3 in flight
        do_reset();
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (m_pend.size() < 3 && k < 20) begin
            step();
            k++;
        end
        chk("C_inflight", 32'(m_pend.size()), 32'd3);
        f_redir = 1'b1;
        f_rpc   = 32'h100;
        step();
        f_redir = 1'b0;
        chk("C_drain_no_req", 32'(imem_req_valid), 32'd0);
        k = 0;
        while (!id_valid && k < 40) begin
            step();
            k++;
        end
        chk("C_first_pc", id_pc, 32'h100);

        // Redirect to misaligned target with same-cycle response and pop
        lat_min = 1;
        lat_max = 1;
        repeat (10) step();
        k = 0;
        while (!(id_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) &&
               k < 10) begin
            step();
            k++;
        end
        chk("D_coincide", 32'(id_valid && mem_q.size() > 0), 32'd1);
        f_redir = 1'b1;
        f_rpc   = 32'h203;
        step();
        f_redir = 1'b0;
        chk("D_empty", 32'(id_valid), 32'd0);
        k = 0;
        while (!imem_req_valid && k < 20) begin
            step();
            k++;
        end
        chk("D_req_addr", imem_req_addr, 32'h200);
        k = 0;
        while (!id_valid && k < 40) begin
            step();
            k++;
        end
        chk("D_first_pc", id_pc, 32'h200);

        // Address wrap at the top of the address space
        f_redir = 1'b1;
        f_rpc   = 32'hFFFF_FFF8;
        step();
        f_redir = 1'b0;
        k = 0;
        while (!(id_valid && id_pc == 32'hFFFF_FFFC) && k < 40) begin
            step();
            k++;
        end
        chk("E_top_pc", id_pc, 32'hFFFF_FFFC);
        chk("E_top_plus4", id_pc_plus4, 32'h0);
        step();
        chk("E_wrap_pc", id_pc, 32'h0);
        repeat (5) step();

        // Asynchronous reset in the middle of a cycle with traffic pending
        p_idr   = 0;
        lat_min = 3;
        lat_max = 3;
        repeat (6) step();
        #2 rst = 1'b0;
        #1 chk_reset_outs("F");
        do_reset();
        lat_min = 1;
        lat_max = 1;
        p_idr   = 100;
        step();
        chk("F_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("F_restart_addr", imem_req_addr, 32'h0);
        repeat (8) step();

        // Randomized traffic
        for (int r = 0; r < 3; r++) begin
            do_reset();
            lat_min = 1;
            lat_max = 4;
            p_rdy   = 70;
            p_idr   = 60;
            p_redir = 30;
            repeat (1500) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
